// File: rtl/mult_err_stats.sv
// Purpose: error statistics (count, ED sum, worst-case ED and its operands) for an approximate 8x8 multiplier.
// Latency: 3-stage pipeline; statistics are final when done rises, 2 cycles after the run's last accept.
// Backpressure: in_ready is high only in RUN and depends on state alone; there is no stall inside the pipeline.
module mult_err_stats #(
  parameter int NUM_SAMPLES = 65536,
  parameter int CNT_W       = 17,
  parameter int SUM_W       = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      approx_r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Index of the final sample: accepting it while sample_cnt holds this value ends the run.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t      state;
  logic        drain_cnt;
  logic        accept;
  logic        run_clr;

  logic        s1_vld;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;
  logic [15:0] s1_r;

  logic        s2_vld;
  logic [7:0]  s2_a;
  logic [7:0]  s2_b;
  logic [15:0] s2_ed;

  logic [15:0] exact;
  logic [16:0] diff;
  logic [15:0] ed;

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;
  // A start honoured from IDLE/DONE wipes the statistics and pipeline for a fresh run.
  assign run_clr  = start && ((state == IDLE) || (state == DONE));

  // Run control: sample counting, RUN->DRAIN on the last accept, two DRAIN cycles, then DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      drain_cnt  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            sample_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_IDX) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Exact product and error distance; the 17-bit difference keeps the sign so the magnitude is exact.
  always_comb begin
    exact = 16'(s1_a) * 16'(s1_b);
    diff  = {1'b0, exact} - {1'b0, s1_r};
    ed    = diff[16] ? 16'(-diff) : diff[15:0];
  end

  // Stage 1 and stage 2 pipeline registers; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (rst || run_clr) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
    end
    if (accept) begin
      s1_a <= in_a;
      s1_b <= in_b;
      s1_r <= approx_r;
    end
    if (s1_vld) begin
      s2_a  <= s1_a;
      s2_b  <= s1_b;
      s2_ed <= ed;
    end
  end

  // Stage 3 accumulation; strict '>' keeps the earliest sample on a tie for the maximum.
  always_ff @(posedge clk) begin
    if (rst || run_clr) begin
      err_cnt <= '0;
      err_sum <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (s2_vld) begin
      err_sum <= err_sum + SUM_W'(s2_ed);
      if (s2_ed != 16'd0) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (s2_ed > max_ed) begin
        max_ed <= s2_ed;
        max_a  <= s2_a;
        max_b  <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_mult_err_stats.sv
// Bench for mult_err_stats: five instances with different run lengths share the sample bus.
// Instances: 0:N=2  1:N=3  2:N=4  3:N=16 (random runs)  4:N=65536 (exhaustive sweep).
// Only the instance that was started is in RUN, so the shared sample bus reaches just that one.
module tb_mult_err_stats;

  localparam int NI = 5;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } smp_t;

  typedef struct {
    longint cnt;
    longint ecnt;
    longint esum;
    longint med;
    longint ma;
    longint mb;
  } stats_t;

  typedef struct {
    int   grp;
    smp_t s;
  } vec_t;

  typedef struct {
    int     inst;
    stats_t e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] approx_r;

  logic        st  [NI];
  logic        rdy [NI];
  logic        bsy [NI];
  logic        dn  [NI];
  logic [16:0] sc  [NI];
  logic [16:0] ec  [NI];
  logic [32:0] es  [NI];
  logic [15:0] me  [NI];
  logic [7:0]  ma  [NI];
  logic [7:0]  mb  [NI];

  int n_cmp;
  int n_bad;

  vec_t tv [10];
  exp_t tx [3];
  smp_t q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 16 : 65536;
    mult_err_stats #(.NUM_SAMPLES(N), .CNT_W(17), .SUM_W(33)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (st[g]),
      .in_valid   (in_valid),
      .in_ready   (rdy[g]),
      .in_a       (in_a),
      .in_b       (in_b),
      .approx_r   (approx_r),
      .busy       (bsy[g]),
      .done       (dn[g]),
      .sample_cnt (sc[g]),
      .err_cnt    (ec[g]),
      .err_sum    (es[g]),
      .max_ed     (me[g]),
      .max_a      (ma[g]),
      .max_b      (mb[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: statistics straight from the definitions, over the whole list of accepted samples.
  function automatic stats_t model(input smp_t qs[$]);
    stats_t s;
    s = '{default: 0};
    foreach (qs[k]) begin
      longint ex;
      longint d;
      ex = longint'(qs[k].a) * longint'(qs[k].b);
      d  = ex - longint'(qs[k].r);
      if (d < 0) d = -d;
      s.cnt++;
      if (d != 0) s.ecnt++;
      s.esum += d;
      if (d > s.med) begin
        s.med = d;
        s.ma  = qs[k].a;
        s.mb  = qs[k].b;
      end
    end
    return s;
  endfunction

  task automatic check_stats(input int i, input string tag, input stats_t e);
    chk({tag, " sample_cnt"}, sc[i], e.cnt);
    chk({tag, " err_cnt"},    ec[i], e.ecnt);
    chk({tag, " err_sum"},    es[i], e.esum);
    chk({tag, " max_ed"},     me[i], e.med);
    chk({tag, " max_a"},      ma[i], e.ma);
    chk({tag, " max_b"},      mb[i], e.mb);
  endtask

  task automatic check_zero(input int i, input string tag);
    stats_t z;
    z = '{default: 0};
    chk({tag, " in_ready"}, rdy[i], 0);
    chk({tag, " busy"},     bsy[i], 0);
    chk({tag, " done"},     dn[i],  0);
    check_stats(i, tag, z);
  endtask

  task automatic start_run(input int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic drive(input logic v, input smp_t s);
    in_valid = v;
    in_a     = s.a;
    in_b     = s.b;
    approx_r = s.r;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int k;
    k = 0;
    while (!dn[i] && k < budget) begin
      tick();
      k++;
    end
    chk({tag, " done reached"}, dn[i], 1);
  endtask

  function automatic smp_t rand_smp();
    smp_t s;
    int   ex;
    int   d;
    s.a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    s.b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    ex  = int'(s.a) * int'(s.b);
    d   = int'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       s.r = 16'(ex);
      1:       s.r = 16'(ex + d);
      2:       s.r = (ex >= d) ? 16'(ex - d) : 16'(ex + d);
      default: s.r = 16'($urandom);
    endcase
    return s;
  endfunction

  initial begin
    stats_t e;
    smp_t   s;
    logic   pat [6];
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    foreach (st[i]) st[i] = 1'b0;
    s = '{8'd0, 8'd0, 16'd0};
    drive(1'b0, s);

    // Directed vectors: {group, a, b, approx} and expected statistics per group.
    tv[0] = '{0, '{8'd3,   8'd5,   16'd15}};
    tv[1] = '{0, '{8'd255, 8'd255, 16'd65025}};
    tv[2] = '{0, '{8'd0,   8'd9,   16'd0}};
    tv[3] = '{0, '{8'd17,  8'd15,  16'd255}};
    tv[4] = '{1, '{8'd255, 8'd255, 16'hFE00}};
    tv[5] = '{1, '{8'd10,  8'd10,  16'h0064}};
    tv[6] = '{2, '{8'd2,   8'd3,   16'd4}};
    tv[7] = '{2, '{8'd4,   8'd1,   16'd2}};
    tv[8] = '{9, '{8'd0,   8'd0,   16'd0}};
    tv[9] = '{9, '{8'd0,   8'd0,   16'd0}};
    tx[0] = '{2, '{4, 0, 0, 0, 0, 0}};
    tx[1] = '{0, '{2, 1, 1, 1, 255, 255}};
    tx[2] = '{0, '{2, 2, 4, 2, 2, 3}};

    // Reset state of every instance.
    tick();
    tick();
    for (int i = 0; i < NI; i++) check_zero(i, $sformatf("reset[%0d]", i));
    rst = 1'b0;
    tick();

    // Table-driven runs: zero-error run, single-error run with done latency, tie handling.
    for (int g = 0; g < 3; g++) begin
      int i;
      i = tx[g].inst;
      start_run(i);
      for (int k = 0; k < 10; k++) begin
        if (tv[k].grp == g) begin
          drive(1'b1, tv[k].s);
          tick();
        end
      end
      drive(1'b0, s);
      chk($sformatf("grp%0d in_ready after last", g), rdy[i], 0);
      chk($sformatf("grp%0d done at accept+1", g), dn[i], 0);
      tick();
      chk($sformatf("grp%0d done at accept+2", g), dn[i], 0);
      tick();
      chk($sformatf("grp%0d done at accept+3", g), dn[i], 1);
      check_stats(i, $sformatf("grp%0d", g), tx[g].e);
    end

    // Bubbles with a start pulse in the middle of RUN: it must not restart the run.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    q.delete();
    start_run(1);
    for (int k = 0; k < 6; k++) begin
      s = rand_smp();
      drive(pat[k], s);
      st[1] = (k == 2);
      if (pat[k]) q.push_back(s);
      tick();
    end
    st[1] = 1'b0;
    drive(1'b0, s);
    chk("bubble in_ready after 3rd", rdy[1], 0);
    chk("bubble busy", bsy[1], 1);
    chk("bubble sample_cnt", sc[1], 3);
    wait_done(1, 6, "bubble");
    check_stats(1, "bubble", model(q));

    // Reset in the middle of a run discards everything; a new run is then clean.
    start_run(2);
    drive(1'b1, '{8'd7, 8'd9, 16'd70});
    tick();
    drive(1'b1, '{8'd20, 8'd20, 16'd390});
    tick();
    drive(1'b0, s);
    tick();
    tick();
    chk("midrun err_sum before reset", es[2], 17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(2, "midrun reset");
    q.delete();
    start_run(2);
    while (q.size() < 4) begin
      s = rand_smp();
      drive(($urandom_range(0, 2) != 0), s);
      if (in_valid) q.push_back(s);
      tick();
    end
    drive(1'b0, s);
    wait_done(2, 6, "after reset");
    check_stats(2, "after reset", model(q));

    // Randomised runs on the 16-sample instance against the reference model.
    for (int run = 0; run < 20; run++) begin
      int guard;
      q.delete();
      guard = 0;
      start_run(3);
      while (q.size() < 16 && guard < 200) begin
        s = rand_smp();
        drive(($urandom_range(0, 3) != 0), s);
        if (in_valid) q.push_back(s);
        tick();
        guard++;
      end
      drive(1'b0, s);
      chk($sformatf("rand%0d in_ready after last", run), rdy[3], 0);
      wait_done(3, 6, $sformatf("rand%0d", run));
      check_stats(3, $sformatf("rand%0d", run), model(q));
    end

    // Exhaustive sweep with approx_r = 0: error distance equals the exact product.
    start_run(4);
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(1'b1, '{8'(a), 8'(b), 16'd0});
        tick();
      end
    end
    drive(1'b0, s);
    wait_done(4, 6, "sweep");
    e = '{65536, 65025, 1065369600, 65025, 255, 255};
    check_stats(4, "sweep", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
